// File: rtl/ide_pio_host.sv
// ide_pio_host: host-side PIO initiator for the IDE task-file port.
// Runs 28-bit-LBA READ SECTORS (0x20) and WRITE SECTORS (0x30) commands
// without a CPU. The 16-bit data words stream to or from a local client.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start             one-cycle command request, sampled only while idle
//   cmd_write         0 = READ SECTORS, 1 = WRITE SECTORS
//   drive, lba, count drive select, 28-bit start LBA, sector count (0 = 256)
//   busy, done        command in progress / one-cycle completion pulse
//   error, err_code   completion status (0 none, 1 device ERR, 2 timeout)
//   err_reg           device error register captured on ERR
//   sectors_done      sectors fully transferred in the current command
//   rd_data/rd_valid  read word stream (no backpressure)
//   wr_data/wr_valid/wr_ack  write word source, word consumed on wr_ack
//   io_*              task-file port master (io_32 tied low)
module ide_pio_host #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_write,
  input  logic        drive,
  input  logic [27:0] lba,
  input  logic [7:0]  count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  err_reg,
  output logic [8:0]  sectors_done,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ack,
  output logic [3:0]  io_address,
  output logic        io_read,
  output logic        io_write,
  output logic [31:0] io_writedata,
  output logic        io_32,
  input  logic [31:0] io_readdata,
  input  logic        io_wait
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_SET_REGS, S_CMD, S_POLL_DRQ,
    S_XFER, S_POLL_END, S_ERR_RD, S_FINISH
  } state_t;

  state_t      state, state_next;
  logic        phase;        // 0: strobe slot, 1: mandatory idle cycle after a strobe
  logic [2:0]  reg_idx;      // which of the five setup registers is next
  logic [7:0]  word_cnt;     // words within the current sector
  logic [23:0] tmo_cnt;
  logic        cmd_write_q, drive_q;
  logic [27:0] lba_q;
  logic [7:0]  count_q;

  logic [7:0]  status;
  logic        polling, timed_out, last_sector;
  logic [7:0]  reg_byte;
  logic        unused_hi;

  assign status      = io_readdata[7:0];
  assign rd_data     = io_readdata[15:0];
  // The port runs in 16-bit mode, so the upper half of the read bus is ignored.
  assign unused_hi   = ^io_readdata[31:16];
  assign io_32       = 1'b0;
  assign busy        = (state != S_IDLE);
  assign error       = (err_code != 2'd0);
  assign polling     = (state == S_WAIT_RDY) || (state == S_POLL_DRQ) || (state == S_POLL_END);
  assign timed_out   = polling && (tmo_cnt == TIMEOUT);
  // A count of 0 encodes 256 sectors: {~|count, count} is the 9-bit total.
  assign last_sector = (sectors_done + 9'd1) == {~|count_q, count_q};

  always_comb begin
    case (reg_idx)
      3'd0:    reg_byte = count_q;
      3'd1:    reg_byte = lba_q[7:0];
      3'd2:    reg_byte = lba_q[15:8];
      3'd3:    reg_byte = lba_q[23:16];
      default: reg_byte = {3'b111, drive_q, lba_q[27:24]};
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_next   = state;
    io_address   = 4'd0;
    io_read      = 1'b0;
    io_write     = 1'b0;
    io_writedata = 32'd0;
    rd_valid     = 1'b0;
    wr_ack       = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_WAIT_RDY;
      S_WAIT_RDY, S_POLL_DRQ, S_POLL_END: begin
        io_address = 4'd7;
        if (timed_out) state_next = S_FINISH;
        else if (!phase) io_read = !io_wait;
        else if (!status[7]) begin
          if (state == S_WAIT_RDY)      state_next = S_SET_REGS;
          else if (status[0])           state_next = S_ERR_RD;
          else if (state == S_POLL_END) state_next = S_FINISH;
          else if (status[3])           state_next = S_XFER;
        end
      end
      S_SET_REGS: begin
        io_address   = {1'b0, reg_idx} + 4'd2;
        io_writedata = {24'd0, reg_byte};
        if (!phase) io_write = !io_wait;
        else if (reg_idx == 3'd4) state_next = S_CMD;
      end
      S_CMD: begin
        io_address   = 4'd7;
        io_writedata = {24'd0, (cmd_write_q ? 8'h30 : 8'h20)};
        if (!phase) io_write = !io_wait;
        else state_next = S_POLL_DRQ;
      end
      S_XFER: begin
        if (!phase) begin
          if (cmd_write_q) begin
            // The source word is forwarded combinationally, so ack and strobe coincide.
            io_writedata = {16'd0, wr_data};
            io_write     = !io_wait && wr_valid;
            wr_ack       = !io_wait && wr_valid;
          end else begin
            io_read = !io_wait;
          end
        end else begin
          rd_valid = !cmd_write_q;
          if (word_cnt == 8'hFF) state_next = last_sector ? S_POLL_END : S_POLL_DRQ;
        end
      end
      S_ERR_RD: begin
        io_address = 4'd1;
        if (!phase) io_read = !io_wait;
        else state_next = S_FINISH;
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      reg_idx      <= 3'd0;
      word_cnt     <= 8'd0;
      tmo_cnt      <= 24'd0;
      cmd_write_q  <= 1'b0;
      drive_q      <= 1'b0;
      lba_q        <= 28'd0;
      count_q      <= 8'd0;
      err_code     <= 2'd0;
      err_reg      <= 8'd0;
      sectors_done <= 9'd0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state   <= state_next;
      phase   <= io_read | io_write;
      // Any state change restarts the count, which covers entry to each poll state.
      tmo_cnt <= (state_next != state) ? 24'd0 : tmo_cnt + 24'd1;
      if (state == S_IDLE && start) begin
        cmd_write_q  <= cmd_write;
        drive_q      <= drive;
        lba_q        <= lba;
        count_q      <= count;
        err_code     <= 2'd0;
        err_reg      <= 8'd0;
        sectors_done <= 9'd0;
        reg_idx      <= 3'd0;
        word_cnt     <= 8'd0;
      end
      if (state == S_SET_REGS && phase) reg_idx <= reg_idx + 3'd1;
      if (state == S_XFER && phase) begin
        word_cnt <= word_cnt + 8'd1;
        if (word_cnt == 8'hFF) sectors_done <= sectors_done + 9'd1;
      end
      if (state == S_ERR_RD && phase) begin
        err_reg  <= status;
        err_code <= 2'd1;
      end
      if (timed_out) err_code <= 2'd2;
    end
  end

endmodule
